// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared widths, FIFO depth and FSM encoding for the RAM stream reader.
// Ports: none (package).
package ram_stream_reader_pkg;

  localparam int unsigned DefAddrWidth = 10;
  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned FifoDepth    = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: valid/ready stream carrying a data word and an end-of-burst flag.
// Signals: valid, data, last (source -> sink), ready (sink -> source).
// Modports: master (stream source), slave (stream sink).
interface ram_stream_reader_if
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry FIFO; entry 0 is always the head so dout_o stays stable until popped.
// Ports: clk/rst_n, push_i + din_i (write), pop_i (read), dout_o (head word),
//        count_o (occupancy 0..2), full_o, empty_o.
// Caller must never push when full without popping, nor pop when empty.
module stream_skid_buf
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = din_i;
        else               ent1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; head advances and the new word joins the tail.
        if (cnt_q == 2'(FifoDepth)) begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end else begin
          ent0_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = ent0_q;
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == 2'(FifoDepth));
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads len consecutive words (wrapping) from a 1-cycle-latency RAM port
// starting at base_addr and presents them on a valid/ready stream, m_last on the final word.
// Ports: clk, rst_n (async, active-low); start/base_addr/len (burst request, IDLE only);
//        busy, done (status); ram_enb/ram_addrb/ram_dob (RAM read port);
//        m (stream master: valid, ready, data, last).
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  ram_stream_reader_if.master   m
);

  localparam logic [ADDR_WIDTH:0] LenOne = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;  // next address to read
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;      // last address issued
  logic [ADDR_WIDTH:0]   left_q, left_d;        // reads still to issue
  logic                  pending_q, pending_d;
  logic                  pend_last_q, pend_last_d;
  logic                  done_q, done_d;

  logic                  push, pop, can_issue;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [1:0]            fifo_count;
  logic                  fifo_full, fifo_empty;

  stream_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ({pend_last_q, ram_dob}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m.valid = ~fifo_empty;
  assign m.data  = fifo_dout[DATA_WIDTH-1:0];
  assign m.last  = fifo_dout[DATA_WIDTH];
  assign pop     = m.valid & m.ready;
  assign push    = pending_q;  // RAM data is valid the cycle after the read was issued
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

  // Issue only if the word will have a slot when it lands: count + pending - pop < 2.
  assign can_issue = (3'(fifo_count) + 3'(pending_q)) < (3'd2 + 3'(pop));
  assign ram_enb   = (state_q == StRead) & can_issue;
  assign ram_addrb = ram_enb ? rd_addr_q : addrb_q;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    addrb_d     = addrb_q;
    left_d      = left_q;
    done_d      = 1'b0;
    pending_d   = ram_enb;
    pend_last_d = ram_enb & (left_q == LenOne);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = StRead;
            rd_addr_d = base_addr;
            left_d    = len;
          end
        end
      end
      StRead: begin
        if (ram_enb) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          left_d    = left_q - LenOne;
          addrb_d   = rd_addr_q;
          if (left_q == LenOne) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m.last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      addrb_q     <= '0;
      left_q      <= '0;
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      addrb_q     <= addrb_d;
      left_q      <= left_d;
      pending_q   <= pending_d;
      pend_last_q <= pend_last_d;
      done_q      <= done_d;
    end
  end

  // Landing data must always find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob = '0;
  logic          m_ready_drv = 1'b1;

  always #5 clk = ~clk;

  ram_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();
  assign s_if.ready = m_ready_drv;

  ram_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob),
    .m         (s_if)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  int            total = 0;
  int            bad = 0;
  word_t         exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] mem[1024];
  int            xfers = 0;
  bit            rdy_rand = 1'b0;
  int unsigned   rdy_pat[16] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_enb) begin
      ram_dob <= mem[ram_addrb];
      addr_log.push_back(ram_addrb);
    end
  end

  // Ready driver: held high, or a fixed irregular pattern.
  initial begin
    int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        m_ready_drv = rdy_pat[idx % 16] != 0;
        idx++;
      end else begin
        m_ready_drv = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            exp_done = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;
    int            out_cnt = 0;
    word_t         w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_done   = 1'b0;
        prev_stall = 1'b0;
        out_cnt    = 0;
      end else begin
        chk("done_timing", done, exp_done);
        chk("outstanding_le2", out_cnt <= 2, 1);
        if (prev_stall) begin
          chk("stall_valid", s_if.valid, 1);
          chk("stall_hold", {s_if.last, s_if.data}, prev_word);
        end
        if (s_if.valid && s_if.ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {s_if.last, s_if.data}, 32'hDEAD_BEEF);
          end else begin
            w = exp_q.pop_front();
            chk("m_data", s_if.data, w.data);
            chk("m_last", s_if.last, w.last);
          end
          xfers++;
        end
        exp_done = (s_if.valid && s_if.ready && s_if.last) || (start && !busy && len == '0);
        prev_stall = s_if.valid && !s_if.ready;
        prev_word  = {s_if.last, s_if.data};
        out_cnt    = out_cnt + int'(ram_enb) - int'(s_if.valid && s_if.ready);
      end
    end
  end

  task automatic drive_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    len       = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    logic [AW-1:0] a;
    for (int k = 0; k < int'(l); k++) begin
      a = b + AW'(k);
      exp_q.push_back({(k == int'(l) - 1), mem[a]});
    end
    drive_start(b, l);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_ram_enb"}, ram_enb, 0);
    chk({name, "_m_valid"}, s_if.valid, 0);
    chk({name, "_m_last"}, s_if.last, 0);
    chk({name, "_ram_addrb"}, ram_addrb, 0);
    chk({name, "_m_data"}, s_if.data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int seen_cnt[1024];
    logic [AW-1:0] a;
    logic [AW-1:0] exp_a4[4];

    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37) ^ 16'h5A00;
    mem[10'h010] = 16'hAAAA;
    mem[10'h011] = 16'hBBBB;
    mem[10'h012] = 16'hCCCC;
    mem[10'h013] = 16'hDDDD;

    // Reset state
    #12;
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic burst: latency, back-to-back words, last, done
    issue_burst(10'h010, 11'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", c), s_if.valid, (c >= 3 && c <= 6));
      if (c == 6) chk("t1_last_on_D", s_if.last, 1);
      if (c == 7) begin
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
      end
    end
    chk("t1_sb_empty", exp_q.size(), 0);

    // Address wrap
    addr_log.delete();
    issue_burst(10'h3FE, 11'd4);
    wait_done(40, "t2_done");
    exp_a4 = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    chk("t2_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk($sformatf("t2_addr%0d", i), addr_log[i], exp_a4[i]);

    // Backpressure plus a start while busy (must be ignored)
    addr_log.delete();
    rdy_rand = 1'b1;
    issue_burst(10'h120, 11'd8);
    drive_start(10'h300, 11'd5);
    wait_done(200, "t3_done");
    rdy_rand = 1'b0;
    chk("t3_nreads", addr_log.size(), 8);
    ok = 1'b1;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != 10'h120 + AW'(i)) ok = 1'b0;
    chk("t3_addr_order", ok, 1);

    // Zero-length request
    @(posedge clk);
    @(posedge clk);
    addr_log.delete();
    issue_burst(10'h055, 11'd0);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      chk("t4_no_enb", ram_enb, 0);
      chk("t4_no_valid", s_if.valid, 0);
      @(negedge clk);
      chk("t4_done_once", done, 0);
    end
    chk("t4_nreads", addr_log.size(), 0);

    // Reset mid-burst, then recover
    begin
      int x0 = xfers;
      int i;
      issue_burst(10'h040, 11'd10);
      for (i = 0; i < 60 && xfers < x0 + 3; i++) @(negedge clk);
      chk("t5_reach3", xfers >= x0 + 3, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero("t5_abort");
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("t5_no_done", done, 0);
        chk("t5_no_busy", busy, 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
    end
    addr_log.delete();
    issue_burst(10'h000, 11'd2);
    wait_done(40, "t5_restart_done");
    chk("t5_nreads", addr_log.size(), 2);

    // Full-RAM burst from mid-memory
    addr_log.delete();
    issue_burst(10'h200, 11'd1024);
    wait_done(1300, "t6_done");
    chk("t6_nreads", addr_log.size(), 1024);
    for (int i = 0; i < 1024; i++) seen_cnt[i] = 0;
    ok = 1'b1;
    for (int i = 0; i < addr_log.size(); i++) begin
      a = 10'h200 + AW'(i);
      if (addr_log[i] != a) ok = 1'b0;
      seen_cnt[addr_log[i]]++;
    end
    chk("t6_addr_order", ok, 1);
    ok = 1'b1;
    for (int i = 0; i < 1024; i++) if (seen_cnt[i] != 1) ok = 1'b0;
    chk("t6_each_once", ok, 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM address width (1024 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, RAM and stream data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first RAM word of the burst, sampled with start.
REQ-007 SHALL have port len  input  ADDR_WIDTH+1  word count 0..1024, sampled with start.
REQ-008 SHALL have port busy  output  1  high from the accepted start until the done pulse.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port ram_enb  output  1  read enable to the RAM read port.
REQ-011 SHALL have port ram_addrb  output  ADDR_WIDTH  read address to the RAM read port.
REQ-012 SHALL have port ram_dob  input  DATA_WIDTH  RAM read data, valid one cycle after the ram_enb edge.
REQ-013 SHALL have port m_valid  output  1  stream word available.
REQ-014 SHALL have port m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.
REQ-015 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-016 SHALL have port m_last  output  1  high with the final word of the burst.

Function
REQ-017 SHALL implement FSM IDLE -> READ (start, len>0) -> DRAIN (all reads issued) -> IDLE (last word transferred); IDLE -> IDLE with done pulse when start and len==0.
REQ-018 SHALL ignore start outside IDLE; it SHALL NOT alter base, length or counters.
REQ-019 SHALL issue reads in READ only; the k-th read (k=0..len-1) uses address (base_addr+k) mod 2^ADDR_WIDTH, wrapping 1023 -> 0.
REQ-020 SHALL track one pending read flag and capture ram_dob into a 2-entry output FIFO in the cycle after each issued read.
REQ-021 SHALL assert ram_enb only when fifo_count + pending - (m_valid & m_ready) < 2, so the FIFO never overflows and no read data is lost.
REQ-022 SHALL sustain one transfer per cycle while m_ready is held high; the first m_valid SHALL rise exactly 2 cycles after the start-sampling edge.
REQ-023 SHALL hold m_data and m_last stable while m_valid is high and m_ready is low.
REQ-024 SHALL assert m_last on exactly the len-th transferred word and on no other word.
REQ-025 SHALL pulse done for exactly one cycle, in the cycle after the m_last transfer (or after start when len==0), and drop busy in that same cycle.
REQ-026 SHALL keep ram_addrb at its last value when ram_enb is low.
REQ-027 SHALL accept len==1024 and read every RAM word exactly once, starting at any base_addr.

Reset
REQ-028 SHALL, while rst_n is low, hold FSM in IDLE, FIFO empty, pending clear and counters zero; busy, done, ram_enb, m_valid and m_last SHALL be 0, and ram_addrb and m_data SHALL be 0.
REQ-029 SHALL abort any burst in progress on reset assertion without a done pulse; an in-flight read SHALL be discarded.

Structure
REQ-030 SHALL place ADDR_WIDTH/DATA_WIDTH defaults and the FSM state encodings (IDLE, READ, DRAIN) in the shared project package/header.
REQ-031 SHALL implement the 2-entry output FIFO as sub-module stream_skid_buf (push, pop, data, count, full/empty).

Verification
REQ-032 SHALL verify base=0x010, len=4, m_ready=1, RAM[0x10..0x13]=A,B,C,D -> m_data A,B,C,D on consecutive cycles, m_valid first high 2 cycles after start, m_last on D, done 1 cycle later.
REQ-033 SHALL verify base=0x3FE, len=4 -> reads at 0x3FE,0x3FF,0x000,0x001 in order.
REQ-034 SHALL verify len=8 with m_ready toggling 1,0,0,1,... random pattern -> all 8 words delivered in order, none duplicated or lost, ram_enb never high with FIFO full and pending set.
REQ-035 SHALL verify start with len=0 -> done pulse next cycle, no ram_enb, no m_valid; start asserted while busy -> ignored.
REQ-036 SHALL verify rst_n dropped mid-burst (after 3 of 10 words) -> all outputs 0 immediately, no done; a new start (base=0, len=2) after release completes normally.
REQ-037 SHALL verify len=1024, base=0x200 -> 1024 transfers covering every address exactly once, m_last only on the word from 0x1FF.
